// File: rtl/pong_pkg.sv
// Shared pong definitions: screen geometry, coordinate width, referee FSM states.
package pong_pkg;

  localparam int unsigned width_screen  = 800;
  localparam int unsigned height_screen = 600;
  localparam int unsigned coord_w       = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// The pulse appears a fixed number of clocks after the input is first sampled high.
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic meta;
  logic sync;
  logic prev;

  // Synchronize the slow input and emit one pulse per rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      meta  <= din;
      sync  <= meta;
      prev  <= sync;
      pulse <= sync & ~prev;
    end
  end

endmodule

// File: rtl/goal_referee.sv
// Goal referee: detects goals on dynamics ticks, paces serves and ends the match.
// Shadow scores exist only to detect match end; the scoreboard holds the displayed score.
module goal_referee #(
  parameter int unsigned width_screen = 800,
  parameter int unsigned ball_size    = 10,
  parameter int unsigned goal_margin  = 4,
  parameter int unsigned max_score    = 9,
  parameter int unsigned serve_ticks  = 60
) (
  input  logic                           px_clk,
  input  logic                           reset,
  input  logic                           dyn_clk,
  input  logic [pong_pkg::coord_w-1:0]   ball_x,
  input  logic                           start,
  output logic                           goal_ply1,
  output logic                           goal_ply2,
  output logic                           score_rst,
  output logic                           serve,
  output logic                           game_over,
  output logic                           winner
);

  import pong_pkg::*;

  localparam int unsigned       cnt_w     = (serve_ticks > 1) ? $clog2(serve_ticks) : 1;
  localparam logic [cnt_w-1:0]  cnt_last  = cnt_w'(serve_ticks - 1);
  localparam logic [10:0]       hit_r_lim = 11'(width_screen + goal_margin);
  localparam logic [3:0]        score_max = 4'(max_score);

  logic             tick;
  logic             hit_r;
  logic             hit_l;
  state_t           state, state_nx;
  logic [cnt_w-1:0] cnt, cnt_nx;
  logic [3:0]       sc1, sc1_nx, sc1_inc;
  logic [3:0]       sc2, sc2_nx, sc2_inc;
  logic             goal1_nx, goal2_nx, score_rst_nx, winner_nx;

  edge_sync u_tick_sync (
    .clk   (px_clk),
    .reset (reset),
    .din   (dyn_clk),
    .pulse (tick)
  );

  // Sums are taken at 11 bits so a ball near the right edge cannot wrap.
  assign hit_r   = ({1'b0, ball_x} + 11'(ball_size)) >= hit_r_lim;
  assign hit_l   = ball_x <= pong_pkg::coord_w'(goal_margin);
  assign sc1_inc = sc1 + 4'd1;
  assign sc2_inc = sc2 + 4'd1;

  // Next-state, serve counter, score and pulse decisions.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    sc1_nx       = sc1;
    sc2_nx       = sc2;
    goal1_nx     = 1'b0;
    goal2_nx     = 1'b0;
    score_rst_nx = 1'b0;
    winner_nx    = winner;
    unique case (state)
      IDLE, OVER: begin
        if (start) begin
          state_nx     = SERVE;
          score_rst_nx = 1'b1;
          sc1_nx       = '0;
          sc2_nx       = '0;
          cnt_nx       = '0;
        end
      end
      SERVE: begin
        if (tick) begin
          if (cnt == cnt_last) begin
            state_nx = PLAY;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      PLAY: begin
        // Right-edge goal takes priority; left is only considered without it.
        if (tick && hit_r) begin
          goal1_nx = 1'b1;
          sc1_nx   = sc1_inc;
          if (sc1_inc == score_max) begin
            state_nx  = OVER;
            winner_nx = 1'b0;
          end else begin
            state_nx = SERVE;
          end
        end else if (tick && hit_l) begin
          goal2_nx = 1'b1;
          sc2_nx   = sc2_inc;
          if (sc2_inc == score_max) begin
            state_nx  = OVER;
            winner_nx = 1'b1;
          end else begin
            state_nx = SERVE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sc1       <= '0;
      sc2       <= '0;
      goal_ply1 <= 1'b0;
      goal_ply2 <= 1'b0;
      score_rst <= 1'b0;
      serve     <= 1'b1;
      game_over <= 1'b0;
      winner    <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      sc1       <= sc1_nx;
      sc2       <= sc2_nx;
      goal_ply1 <= goal1_nx;
      goal_ply2 <= goal2_nx;
      score_rst <= score_rst_nx;
      serve     <= (state_nx != PLAY);
      game_over <= (state_nx == OVER);
      winner    <= winner_nx;
    end
  end

endmodule

// File: tb/tb_goal_referee.sv
// Directed self-checking bench for goal_referee.
module tb_goal_referee;

  logic       px_clk = 1'b0;
  logic       reset  = 1'b1;
  logic       dyn_clk = 1'b0;
  logic [9:0] ball_x = 10'd400;
  logic       start  = 1'b0;
  logic       goal_ply1, goal_ply2, score_rst, serve, game_over, winner;

  int checks = 0;
  int errors = 0;
  int g1_seen = 0;
  int g2_seen = 0;
  int rst_seen = 0;

  goal_referee #(
    .width_screen (800),
    .ball_size    (10),
    .goal_margin  (4),
    .max_score    (9),
    .serve_ticks  (60)
  ) dut (
    .px_clk    (px_clk),
    .reset     (reset),
    .dyn_clk   (dyn_clk),
    .ball_x    (ball_x),
    .start     (start),
    .goal_ply1 (goal_ply1),
    .goal_ply2 (goal_ply2),
    .score_rst (score_rst),
    .serve     (serve),
    .game_over (game_over),
    .winner    (winner)
  );

  always #5 px_clk = ~px_clk;

  // Pulse counters sampled away from the active edge.
  always @(negedge px_clk) begin
    if (goal_ply1) g1_seen++;
    if (goal_ply2) g2_seen++;
    if (score_rst) rst_seen++;
  end

  task automatic tick();
    @(negedge px_clk) dyn_clk = 1'b1;
    repeat (5) @(negedge px_clk);
    dyn_clk = 1'b0;
    repeat (5) @(negedge px_clk);
  endtask

  task automatic go_play();
    repeat (60) tick();
  endtask

  task automatic pulse_start();
    @(negedge px_clk) start = 1'b1;
    @(negedge px_clk) start = 1'b0;
    repeat (2) @(negedge px_clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge px_clk);
    checks++; if (serve !== 1'b1) begin errors++; $display("FAIL reset_serve got %b exp 1", serve); end
    checks++; if ({goal_ply1, goal_ply2, score_rst, game_over, winner} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs got %b exp 00000", {goal_ply1, goal_ply2, score_rst, game_over, winner});
    end
    reset = 1'b0;
    @(negedge px_clk);
  endtask

  task automatic test_idle();
    int g1, g2;
    g1 = g1_seen; g2 = g2_seen;
    ball_x = 10'd4;
    repeat (3) tick();
    checks++; if (g2_seen - g2 + g1_seen - g1 !== 0) begin errors++; $display("FAIL idle_no_goal got %0d exp 0", g2_seen - g2 + g1_seen - g1); end
    checks++; if (serve !== 1'b1) begin errors++; $display("FAIL idle_serve got %b exp 1", serve); end
    ball_x = 10'd400;
  endtask

  task automatic test_start();
    @(negedge px_clk) start = 1'b1;
    @(negedge px_clk) start = 1'b0;
    checks++; if (score_rst !== 1'b1) begin errors++; $display("FAIL start_score_rst got %b exp 1", score_rst); end
    @(negedge px_clk);
    checks++; if (score_rst !== 1'b0) begin errors++; $display("FAIL start_score_rst_width got %b exp 0", score_rst); end
    repeat (59) tick();
    checks++; if (serve !== 1'b1) begin errors++; $display("FAIL serve_59_ticks got %b exp 1", serve); end
    tick();
    checks++; if (serve !== 1'b0) begin errors++; $display("FAIL serve_60_ticks got %b exp 0", serve); end
  endtask

  task automatic test_goal_latency();
    int g1, g2;
    g1 = g1_seen; g2 = g2_seen;
    ball_x = 10'd796;
    repeat (3) @(negedge px_clk);
    checks++; if (g1_seen - g1 !== 0) begin errors++; $display("FAIL no_tick_no_goal got %0d exp 0", g1_seen - g1); end
    dyn_clk = 1'b1;
    repeat (3) @(negedge px_clk);
    checks++; if (goal_ply1 !== 1'b0) begin errors++; $display("FAIL goal1_early got %b exp 0", goal_ply1); end
    @(negedge px_clk);
    checks++; if ({goal_ply1, goal_ply2, serve} !== 3'b101) begin
      errors++; $display("FAIL goal1_latency got g1/g2/serve %b exp 101", {goal_ply1, goal_ply2, serve});
    end
    @(negedge px_clk);
    checks++; if (goal_ply1 !== 1'b0) begin errors++; $display("FAIL goal1_width got %b exp 0", goal_ply1); end
    dyn_clk = 1'b0;
    repeat (5) @(negedge px_clk);
    g1 = g1_seen;
    tick();
    checks++; if (g1_seen - g1 !== 0) begin errors++; $display("FAIL serve_no_goal got %0d exp 0", g1_seen - g1); end
    ball_x = 10'd400;
  endtask

  task automatic test_boundaries();
    int g1, g2;
    go_play();
    g1 = g1_seen; g2 = g2_seen;
    ball_x = 10'd793;
    tick();
    checks++; if (g1_seen - g1 !== 0 || serve !== 1'b0) begin
      errors++; $display("FAIL right_793 got goals %0d serve %b exp 0 0", g1_seen - g1, serve);
    end
    ball_x = 10'd794;
    tick();
    checks++; if (g1_seen - g1 !== 1 || g2_seen - g2 !== 0) begin
      errors++; $display("FAIL right_794 got g1 %0d g2 %0d exp 1 0", g1_seen - g1, g2_seen - g2);
    end
    ball_x = 10'd400;
    go_play();
    g1 = g1_seen; g2 = g2_seen;
    ball_x = 10'd5;
    tick();
    checks++; if (g2_seen - g2 !== 0 || serve !== 1'b0) begin
      errors++; $display("FAIL left_5 got goals %0d serve %b exp 0 0", g2_seen - g2, serve);
    end
    ball_x = 10'd4;
    tick();
    checks++; if (g2_seen - g2 !== 1 || g1_seen - g1 !== 0) begin
      errors++; $display("FAIL left_4 got g2 %0d g1 %0d exp 1 0", g2_seen - g2, g1_seen - g1);
    end
    ball_x = 10'd400;
  endtask

  task automatic test_dyn_held();
    repeat (58) tick();
    @(negedge px_clk) dyn_clk = 1'b1;
    repeat (100) @(negedge px_clk);
    dyn_clk = 1'b0;
    repeat (5) @(negedge px_clk);
    checks++; if (serve !== 1'b1) begin errors++; $display("FAIL dyn_held_one_tick serve got %b exp 1", serve); end
    tick();
    checks++; if (serve !== 1'b0) begin errors++; $display("FAIL dyn_held_then_play serve got %b exp 0", serve); end
  endtask

  task automatic test_match();
    int g2;
    @(negedge px_clk) reset = 1'b1;
    @(negedge px_clk) reset = 1'b0;
    pulse_start();
    g2 = g2_seen;
    for (int i = 1; i <= 9; i++) begin
      go_play();
      ball_x = 10'd0;
      tick();
      ball_x = 10'd400;
      if (i == 8) begin
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL over_after_8 got %b exp 0", game_over); end
      end
    end
    checks++; if (g2_seen - g2 !== 9) begin errors++; $display("FAIL p2_goals got %0d exp 9", g2_seen - g2); end
    checks++; if ({game_over, winner, serve} !== 3'b111) begin
      errors++; $display("FAIL match_end got over/winner/serve %b exp 111", {game_over, winner, serve});
    end
    g2 = g2_seen;
    ball_x = 10'd0;
    repeat (3) tick();
    checks++; if (g2_seen - g2 !== 0) begin errors++; $display("FAIL over_no_goal got %0d exp 0", g2_seen - g2); end
    ball_x = 10'd400;
  endtask

  task automatic test_restart();
    int r, g1;
    r = rst_seen;
    @(negedge px_clk) start = 1'b1;
    repeat (10) @(negedge px_clk);
    checks++; if (rst_seen - r !== 1) begin errors++; $display("FAIL restart_once got %0d exp 1", rst_seen - r); end
    checks++; if ({game_over, serve} !== 2'b01) begin
      errors++; $display("FAIL restart_state got over/serve %b exp 01", {game_over, serve});
    end
    go_play();
    checks++; if (serve !== 1'b0 || rst_seen - r !== 1) begin
      errors++; $display("FAIL start_in_play got serve %b rst %0d exp 0 1", serve, rst_seen - r);
    end
    g1 = g1_seen;
    ball_x = 10'd796;
    tick();
    start = 1'b0;
    ball_x = 10'd400;
    checks++; if (g1_seen - g1 !== 1 || game_over !== 1'b0) begin
      errors++; $display("FAIL fresh_score got g1 %0d over %b exp 1 0", g1_seen - g1, game_over);
    end
  endtask

  task automatic test_reset_mid();
    int g, r;
    repeat (30) tick();
    @(negedge px_clk) reset = 1'b1;
    @(negedge px_clk);
    checks++; if ({serve, game_over, goal_ply1, goal_ply2, score_rst} !== 5'b10000) begin
      errors++; $display("FAIL mid_reset got %b exp 10000", {serve, game_over, goal_ply1, goal_ply2, score_rst});
    end
    reset = 1'b0;
    g = g1_seen + g2_seen; r = rst_seen;
    ball_x = 10'd4;
    repeat (31) tick();
    checks++; if (serve !== 1'b1 || g1_seen + g2_seen - g !== 0 || rst_seen - r !== 0) begin
      errors++; $display("FAIL mid_reset_idle got serve %b goals %0d rst %0d exp 1 0 0", serve, g1_seen + g2_seen - g, rst_seen - r);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_start();
    test_goal_latency();
    test_boundaries();
    test_dyn_held();
    test_match();
    test_restart();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
